// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants, state enum and index-width helper for matrix control blocks
package mat_pkg;

  localparam int DEF_ROWS   = 8;
  localparam int DEF_COLS   = 8;
  localparam int DEF_ADDR_W = 8;

  localparam logic ORD_ROW = 1'b0;
  localparam logic ORD_COL = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // An index register needs at least one bit even for a single-entry dimension.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-(MAX+1) counter with clear, load-zero, increment enable and terminal count
module wrap_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 7
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_zero,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_zero) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == MAX_V);

endmodule

// File: rtl/mat_addr_gen.sv
// rtl/mat_addr_gen.sv - row-major matrix address walker with column- or row-major traversal order
module mat_addr_gen
  import mat_pkg::*;
#(
  parameter  int ROWS   = DEF_ROWS,
  parameter  int COLS   = DEF_COLS,
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int RI_W   = idx_w(ROWS),
  localparam int CI_W   = idx_w(COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              col_major,
  input  logic              step,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic [RI_W-1:0]   row_idx,
  output logic [CI_W-1:0]   col_idx,
  output logic              valid,
  output logic              busy,
  output logic              line_last,
  output logic              done
);

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mode_q, mode_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic accept, run_step, last_elem, r_tc, c_tc, r_inc, c_inc;
  logic [RI_W-1:0] r_cnt;
  logic [CI_W-1:0] c_cnt;

  assign accept    = (state_q == ST_IDLE) && start && !abort;
  assign run_step  = (state_q == ST_RUN) && step && !abort;
  assign last_elem = r_tc && c_tc;

  // The inner dimension counts every step; the outer one only when the inner wraps.
  assign r_inc = run_step && !last_elem && ((mode_q == ORD_COL) ? 1'b1 : c_tc);
  assign c_inc = run_step && !last_elem && ((mode_q == ORD_COL) ? r_tc : 1'b1);

  wrap_counter #(.WIDTH(RI_W), .MAX(ROWS - 1)) u_row_cnt (
    .clk       (clk),
    .clear     (reset),
    .load_zero (accept),
    .inc       (r_inc),
    .count     (r_cnt),
    .tc        (r_tc)
  );

  wrap_counter #(.WIDTH(CI_W), .MAX(COLS - 1)) u_col_cnt (
    .clk       (clk),
    .clear     (reset),
    .load_zero (accept),
    .inc       (c_inc),
    .count     (c_cnt),
    .tc        (c_tc)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else if (accept) begin
      state_d = ST_RUN;
      base_d  = base;
      mode_d  = col_major;
      addr_d  = base;
      valid_d = 1'b1;
    end else if (run_step) begin
      if (last_elem) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else if (mode_q == ORD_COL) begin
        // Column change restarts from base so column-top addresses never drift.
        addr_d = r_tc ? (base_q + ADDR_W'(c_cnt) + 1'b1) : (addr_q + COLS_A);
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      mode_q  <= ORD_ROW;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign addr      = addr_q;
  assign row_idx   = r_cnt;
  assign col_idx   = c_cnt;
  assign valid     = valid_q;
  assign busy      = valid_q;
  assign done      = done_q;
  assign line_last = valid_q && ((mode_q == ORD_COL) ? r_tc : c_tc);

endmodule

// File: tb/tb_mat_addr_gen.sv
// tb/tb_mat_addr_gen.sv - directed self-checking bench for mat_addr_gen (8x8, 3x5 and 1x1 instances)
module tb_mat_addr_gen;

  logic       clk = 1'b0;
  logic       reset, start, col_major, step, abort;
  logic [7:0] base;

  logic [7:0] a88;  logic [2:0] r88; logic [2:0] c88;
  logic       v88, b88, ll88, d88;
  logic [7:0] a35;  logic [1:0] r35; logic [2:0] c35;
  logic       v35, b35, ll35, d35;
  logic [7:0] a11;  logic [0:0] r11; logic [0:0] c11;
  logic       v11, b11, ll11, d11;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_addr_gen #(.ROWS(8), .COLS(8), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .col_major(col_major),
    .step(step), .abort(abort), .addr(a88), .row_idx(r88), .col_idx(c88),
    .valid(v88), .busy(b88), .line_last(ll88), .done(d88)
  );

  mat_addr_gen #(.ROWS(3), .COLS(5), .ADDR_W(8)) dut35 (
    .clk(clk), .reset(reset), .start(start), .base(base), .col_major(col_major),
    .step(step), .abort(abort), .addr(a35), .row_idx(r35), .col_idx(c35),
    .valid(v35), .busy(b35), .line_last(ll35), .done(d35)
  );

  mat_addr_gen #(.ROWS(1), .COLS(1), .ADDR_W(8)) dut11 (
    .clk(clk), .reset(reset), .start(start), .base(base), .col_major(col_major),
    .step(step), .abort(abort), .addr(a11), .row_idx(r11), .col_idx(c11),
    .valid(v11), .busy(b11), .line_last(ll11), .done(d11)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle88(input string tag);
    chk({tag, "_valid"}, 32'(v88), 32'd0);
    chk({tag, "_busy"}, 32'(b88), 32'd0);
    chk({tag, "_done"}, 32'(d88), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; col_major = 1'b0; step = 1'b0; abort = 1'b0; base = 8'h00;
    tick(); tick();
    chk("rst_addr", 32'(a88), 32'd0);
    chk("rst_row", 32'(r88), 32'd0);
    chk("rst_col", 32'(c88), 32'd0);
    chk("rst_ll", 32'(ll88), 32'd0);
    chk("rst_ll11", 32'(ll11), 32'd0);
    chk_idle88("rst");
    reset = 1'b0;
    tick();

    // 8x8 column-major from base 0, step every cycle
    start = 1'b1; col_major = 1'b1; base = 8'h00;
    tick();
    start = 1'b0; step = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("cm_addr_%0d", k), 32'(a88), 32'((k % 8) * 8 + k / 8));
      chk($sformatf("cm_ll_%0d", k), 32'(ll88), 32'((k % 8) == 7));
      chk($sformatf("cm_busy_%0d", k), 32'(b88), 32'd1);
      if (k == 0) chk("one_valid", 32'(v11), 32'd1);
      if (k == 1) begin
        chk("one_done", 32'(d11), 32'd1);
        chk("one_valid_off", 32'(v11), 32'd0);
      end
      if (k == 2) chk("one_done_pulse", 32'(d11), 32'd0);
      tick();
    end
    chk("cm_done", 32'(d88), 32'd1);
    chk("cm_valid_off", 32'(v88), 32'd0);
    chk("cm_addr_hold", 32'(a88), 32'd63);

    // start on the done cycle: 8x8 row-major from 0x10
    start = 1'b1; col_major = 1'b0; base = 8'h10; step = 1'b0;
    tick();
    chk("rm_done_pulse", 32'(d88), 32'd0);
    start = 1'b0; step = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("rm_addr_%0d", k), 32'(a88), 32'(8'h10 + k));
      chk($sformatf("rm_row_%0d", k), 32'(r88), 32'(k / 8));
      chk($sformatf("rm_col_%0d", k), 32'(c88), 32'(k % 8));
      chk($sformatf("rm_ll_%0d", k), 32'(ll88), 32'((k % 8) == 7));
      tick();
    end
    chk("rm_done", 32'(d88), 32'd1);
    step = 1'b0;
    tick();
    chk("rm_done_one", 32'(d88), 32'd0);

    // 3x5 column-major from 0xF8 with 8-bit wrap
    start = 1'b1; col_major = 1'b1; base = 8'hF8;
    tick();
    start = 1'b0; step = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("w35_addr_%0d", k), 32'(a35), 32'(8'(8'hF8 + (k % 3) * 5 + k / 3)));
      chk($sformatf("w35_ll_%0d", k), 32'(ll35), 32'((k % 3) == 2));
      tick();
    end
    chk("w35_done", 32'(d35), 32'd1);
    step = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle88("abort_idle");

    // gapped steps with start pulses during RUN, 8x8 column-major from 0x20
    start = 1'b1; col_major = 1'b1; base = 8'h20;
    tick();
    base = 8'h99;
    for (int k = 0; k < 12; k++) begin
      for (int g = 0; g < 2; g++) begin
        start = 1'b1; step = 1'b0;
        tick();
        chk($sformatf("gap_addr_%0d_%0d", k, g), 32'(a88), 32'(8'h20 + (k % 8) * 8 + k / 8));
        chk($sformatf("gap_row_%0d_%0d", k, g), 32'(r88), 32'(k % 8));
        chk($sformatf("gap_valid_%0d_%0d", k, g), 32'(v88), 32'd1);
      end
      start = 1'b0; step = 1'b1;
      tick();
    end
    chk("gap_addr_end", 32'(a88), 32'(8'h20 + 4 * 8 + 1));
    step = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;

    // abort at element 20 together with step and start, then restart at 0x40
    start = 1'b1; col_major = 1'b1; base = 8'h00;
    tick();
    start = 1'b0; step = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("ab_elem20", 32'(a88), 32'(4 * 8 + 2));
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; step = 1'b0;
    chk_idle88("ab_now");
    tick();
    chk_idle88("ab_after");
    start = 1'b1; base = 8'h40;
    tick();
    start = 1'b0;
    chk("re_addr", 32'(a88), 32'h40);
    chk("re_row", 32'(r88), 32'd0);
    chk("re_col", 32'(c88), 32'd0);
    chk("re_valid", 32'(v88), 32'd1);
    step = 1'b1;
    tick();
    chk("re_addr1", 32'(a88), 32'h48);
    chk("re_row1", 32'(r88), 32'd1);

    // reset mid-walk with step and start asserted
    tick(); tick();
    reset = 1'b1; start = 1'b1;
    tick();
    chk("mr_addr", 32'(a88), 32'd0);
    chk("mr_row", 32'(r88), 32'd0);
    chk("mr_col", 32'(c88), 32'd0);
    chk("mr_ll", 32'(ll88), 32'd0);
    chk_idle88("mr");
    reset = 1'b0; start = 1'b0;
    tick();
    chk_idle88("mr_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
